// File: rtl/dcache_line_master_pkg.sv
// Shared types for the L1 data-cache line master: command opcodes, FSM states
// and response error codes.
package dcache_line_master_pkg;

    typedef enum logic [1:0] {
        OP_REFILL    = 2'd0,
        OP_WB        = 2'd1,
        OP_WB_REFILL = 2'd2,
        OP_RSVD      = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_W_REQ  = 3'd1,
        ST_W_WAIT = 3'd2,
        ST_R_REQ  = 3'd3,
        ST_R_WAIT = 3'd4,
        ST_RESP   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        RESP_OK      = 2'd0,
        RESP_BUS     = 2'd1,
        RESP_TIMEOUT = 2'd2,
        RESP_BADOP   = 2'd3
    } resp_err_t;

    localparam int LINE_BYTES  = 16;
    localparam int LINE_OFFSET = 4;

    // Number of byte-offset address bits inside one line of the given width.
    function automatic int line_offset_bits(input int line_width);
        return $clog2(line_width / 8);
    endfunction

endpackage

// File: rtl/dcache_line_master_timer.sv
// Reply watchdog: counts wait cycles and flags the terminal count.
module mem_reply_timer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TERMINAL = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_r;

    // Wait-cycle counter; saturates at the terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CW{1'b0}};
        end else if (clr) begin
            count_r <= {CW{1'b0}};
        end else if (en && (count_r != TERMINAL)) begin
            count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = en && (count_r == TERMINAL);

endmodule

// File: rtl/dcache_line_master.sv
// Mem_ift line master: runs one refill / writeback / writeback-then-refill
// command at a time and returns a single response to the cache controller.
module dcache_line_master
    import dcache_line_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int LINE_WIDTH     = 128,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_victim_addr,
    input  logic [LINE_WIDTH-1:0] cmd_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [LINE_WIDTH-1:0] resp_rdata,
    output logic [1:0]            resp_err,
    output logic                  r_request_valid,
    input  logic                  r_request_ready,
    output logic [ADDR_WIDTH-1:0] raddr,
    input  logic                  r_reply_valid,
    input  logic [LINE_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    output logic                  w_request_valid,
    input  logic                  w_request_ready,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [LINE_WIDTH-1:0] wdata,
    input  logic                  w_reply_valid,
    input  logic [1:0]            bresp
);

    localparam int OFF_BITS = line_offset_bits(LINE_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK =
        ~((ADDR_WIDTH'(1) << OFF_BITS) - ADDR_WIDTH'(1));

    state_t state_r;
    op_t    op_r;
    logic   timer_clr_s;
    logic   timer_en_s;
    logic   timer_expired_s;

    // Timer restarts on each request handshake, so it only spans the wait state.
    assign timer_clr_s = ((state_r == ST_W_REQ) && w_request_valid && w_request_ready) ||
                         ((state_r == ST_R_REQ) && r_request_valid && r_request_ready);
    assign timer_en_s  = (state_r == ST_W_WAIT) || (state_r == ST_R_WAIT);
    assign cmd_ready   = (state_r == ST_IDLE) && !rst;

    mem_reply_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr_s),
        .en      (timer_en_s),
        .expired (timer_expired_s)
    );

    // Command sequencer with registered bus and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            op_r            <= OP_REFILL;
            raddr           <= {ADDR_WIDTH{1'b0}};
            waddr           <= {ADDR_WIDTH{1'b0}};
            wdata           <= {LINE_WIDTH{1'b0}};
            r_request_valid <= 1'b0;
            w_request_valid <= 1'b0;
            resp_valid      <= 1'b0;
            resp_rdata      <= {LINE_WIDTH{1'b0}};
            resp_err        <= RESP_OK;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_r       <= op_t'(cmd_op);
                        resp_rdata <= {LINE_WIDTH{1'b0}};
                        resp_err   <= RESP_OK;
                        case (op_t'(cmd_op))
                            OP_REFILL: begin
                                raddr           <= cmd_addr & OFF_MASK;
                                waddr           <= cmd_victim_addr & OFF_MASK;
                                wdata           <= cmd_wdata;
                                r_request_valid <= 1'b1;
                                state_r         <= ST_R_REQ;
                            end
                            OP_WB, OP_WB_REFILL: begin
                                raddr           <= cmd_addr & OFF_MASK;
                                waddr           <= cmd_victim_addr & OFF_MASK;
                                wdata           <= cmd_wdata;
                                w_request_valid <= 1'b1;
                                state_r         <= ST_W_REQ;
                            end
                            default: begin
                                resp_err   <= RESP_BADOP;
                                resp_valid <= 1'b1;
                                state_r    <= ST_RESP;
                            end
                        endcase
                    end
                end
                ST_W_REQ: begin
                    // Slave re-accepts a held request, so valid drops right after the handshake.
                    if (w_request_ready) begin
                        w_request_valid <= 1'b0;
                        state_r         <= ST_W_WAIT;
                    end
                end
                ST_W_WAIT: begin
                    if (w_reply_valid) begin
                        if (bresp != 2'b00) begin
                            resp_err   <= RESP_BUS;
                            resp_valid <= 1'b1;
                            state_r    <= ST_RESP;
                        end else if (op_r == OP_WB) begin
                            resp_err   <= RESP_OK;
                            resp_valid <= 1'b1;
                            state_r    <= ST_RESP;
                        end else begin
                            r_request_valid <= 1'b1;
                            state_r         <= ST_R_REQ;
                        end
                    end else if (timer_expired_s) begin
                        resp_err   <= RESP_TIMEOUT;
                        resp_rdata <= {LINE_WIDTH{1'b0}};
                        resp_valid <= 1'b1;
                        state_r    <= ST_RESP;
                    end
                end
                ST_R_REQ: begin
                    if (r_request_ready) begin
                        r_request_valid <= 1'b0;
                        state_r         <= ST_R_WAIT;
                    end
                end
                ST_R_WAIT: begin
                    // A reply on the terminal-count cycle beats the timeout.
                    if (r_reply_valid) begin
                        resp_rdata <= rdata;
                        resp_err   <= (rresp != 2'b00) ? RESP_BUS : RESP_OK;
                        resp_valid <= 1'b1;
                        state_r    <= ST_RESP;
                    end else if (timer_expired_s) begin
                        resp_err   <= RESP_TIMEOUT;
                        resp_rdata <= {LINE_WIDTH{1'b0}};
                        resp_valid <= 1'b1;
                        state_r    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state_r    <= ST_IDLE;
                    end
                end
                default: begin
                    r_request_valid <= 1'b0;
                    w_request_valid <= 1'b0;
                    resp_valid      <= 1'b0;
                    state_r         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_line_master.sv
// Randomized bench for dcache_line_master against a transaction-level model
// of the expected response, latency and bus traffic.
module tb_dcache_line_master;

    localparam int TC = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [31:0]  cmd_addr;
    logic [31:0]  cmd_victim_addr;
    logic [127:0] cmd_wdata;
    logic         resp_valid;
    logic         resp_ready;
    logic [127:0] resp_rdata;
    logic [1:0]   resp_err;
    logic         r_request_valid;
    logic         r_request_ready;
    logic [31:0]  raddr;
    logic         r_reply_valid;
    logic [127:0] rdata;
    logic [1:0]   rresp;
    logic         w_request_valid;
    logic         w_request_ready;
    logic [31:0]  waddr;
    logic [127:0] wdata;
    logic         w_reply_valid;
    logic [1:0]   bresp;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dcache_line_master #(
        .ADDR_WIDTH     (32),
        .LINE_WIDTH     (128),
        .TIMEOUT_CYCLES (TC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_addr        (cmd_addr),
        .cmd_victim_addr (cmd_victim_addr),
        .cmd_wdata       (cmd_wdata),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_rdata      (resp_rdata),
        .resp_err        (resp_err),
        .r_request_valid (r_request_valid),
        .r_request_ready (r_request_ready),
        .raddr           (raddr),
        .r_reply_valid   (r_reply_valid),
        .rdata           (rdata),
        .rresp           (rresp),
        .w_request_valid (w_request_valid),
        .w_request_ready (w_request_ready),
        .waddr           (waddr),
        .wdata           (wdata),
        .w_reply_valid   (w_reply_valid),
        .bresp           (bresp)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cmd_valid = 1'b0; resp_ready = 1'b0;
        r_request_ready = 1'b0; w_request_ready = 1'b0;
        r_reply_valid = 1'b0; w_reply_valid = 1'b0;
        rresp = 2'b00; bresp = 2'b00;
    endtask

    function automatic logic [127:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Replies outside a wait state must leave every output untouched.
    task automatic stray_reply();
        logic [127:0] held;
        held = resp_rdata;
        r_reply_valid = 1'b1; w_reply_valid = 1'b1;
        rdata = rnd_line(); rresp = 2'b11; bresp = 2'b11;
        tick();
        clear_inputs();
        chk("stray_resp_valid", 128'(resp_valid), 128'(0));
        chk("stray_cmd_ready", 128'(cmd_ready), 128'(1));
        chk("stray_rvalid", 128'(r_request_valid), 128'(0));
        chk("stray_wvalid", 128'(w_request_valid), 128'(0));
        chk("stray_rdata", resp_rdata, held);
    endtask

    // Issue one command, play the slave, and check against the model.
    // *_lat = cycles from handshake to reply; lat > TC means the slave never replies.
    task automatic run_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] vaddr,
                           input logic [127:0] line_w, input int w_dly, input int w_lat,
                           input logic [1:0] bresp_v, input int r_dly, input int r_lat,
                           input logic [127:0] line_r, input logic [1:0] rresp_v, input int resp_dly);
        bit has_w, has_r, chk_data, done, w_rep_done;
        int exp_cyc, c, w_hs, r_hs, w_wait, r_wait, w_rep_at, r_rep_at, resp_at;
        logic [1:0] exp_err;
        logic [127:0] exp_data, held_d;
        logic [1:0] held_e;

        has_w = (op == 2'd1) || (op == 2'd2);
        has_r = 1'b0; chk_data = 1'b1; exp_cyc = 1; exp_data = 128'd0;
        if (op == 2'd3) begin
            exp_err = 2'd3;
        end else begin
            exp_err = 2'd0;
            if (has_w) begin
                if (w_lat > TC) begin exp_err = 2'd2; exp_cyc += w_dly + TC + 1; end
                else begin exp_cyc += w_dly + w_lat + 1; if (bresp_v != 2'b00) exp_err = 2'd1; end
            end
            if (exp_err == 2'd0 && op != 2'd1) begin
                has_r = 1'b1;
                if (r_lat > TC) begin exp_err = 2'd2; exp_cyc += r_dly + TC + 1; end
                else begin
                    exp_cyc += r_dly + r_lat + 1;
                    if (rresp_v != 2'b00) begin exp_err = 2'd1; chk_data = 1'b0; end
                    else exp_data = line_r;
                end
            end
        end

        chk("cmd_ready", 128'(cmd_ready), 128'(1));
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_victim_addr = vaddr; cmd_wdata = line_w;
        tick();
        cmd_valid = 1'b0;
        cmd_addr = $urandom; cmd_victim_addr = $urandom; cmd_wdata = rnd_line();
        c = 1; w_hs = 0; r_hs = 0; w_wait = 0; r_wait = 0;
        w_rep_at = -1; r_rep_at = -1; resp_at = -1; done = 1'b0; w_rep_done = 1'b0;
        held_d = 128'd0; held_e = 2'd0;
        while (!done && c < 300) begin
            clear_inputs();
            chk("one_req", 128'(r_request_valid && w_request_valid), 128'(0));
            if (w_request_valid) begin
                chk("w_single", 128'(w_hs), 128'(0));
                chk("waddr", 128'(waddr), 128'(vaddr & 32'hFFFF_FFF0));
                chk("wdata", wdata, line_w);
                if (w_wait >= w_dly) begin
                    w_request_ready = 1'b1; w_hs++;
                    if (w_lat <= TC) w_rep_at = c + w_lat;
                end
                w_wait++;
            end
            if (r_request_valid) begin
                chk("r_single", 128'(r_hs), 128'(0));
                chk("r_after_w", 128'(w_rep_done), 128'(has_w));
                chk("raddr", 128'(raddr), 128'(addr & 32'hFFFF_FFF0));
                if (r_wait >= r_dly) begin
                    r_request_ready = 1'b1; r_hs++;
                    if (r_lat <= TC) r_rep_at = c + r_lat;
                end
                r_wait++;
            end
            if (c == w_rep_at) begin w_reply_valid = 1'b1; bresp = bresp_v; w_rep_done = 1'b1; end
            if (c == r_rep_at) begin r_reply_valid = 1'b1; rresp = rresp_v; rdata = line_r; end
            if (resp_valid) begin
                if (resp_at < 0) begin
                    resp_at = c;
                    chk("resp_cycle", 128'(c), 128'(exp_cyc));
                    chk("resp_err", 128'(resp_err), 128'(exp_err));
                    if (chk_data) chk("resp_rdata", resp_rdata, exp_data);
                    held_d = resp_rdata; held_e = resp_err;
                end else begin
                    chk("resp_hold_data", resp_rdata, held_d);
                    chk("resp_hold_err", 128'(resp_err), 128'(held_e));
                end
                w_reply_valid = 1'b1; r_reply_valid = 1'b1;
                rdata = rnd_line(); rresp = 2'b01; bresp = 2'b01;
                if (c - resp_at >= resp_dly) begin resp_ready = 1'b1; done = 1'b1; end
            end
            tick();
            c++;
        end
        clear_inputs();
        chk("resp_seen", 128'(done), 128'(1));
        chk("resp_drop", 128'(resp_valid), 128'(0));
        chk("w_hs_count", 128'(w_hs), 128'(has_w ? 1 : 0));
        chk("r_hs_count", 128'(r_hs), 128'(has_r ? 1 : 0));
    endtask

    initial begin
        logic [1:0] op;
        rst = 1'b1;
        clear_inputs();
        cmd_op = 2'd0; cmd_addr = 32'd0; cmd_victim_addr = 32'd0; cmd_wdata = 128'd0; rdata = 128'd0;
        repeat (2) tick();
        chk("rst_cmd_ready", 128'(cmd_ready), 128'(0));
        chk("rst_resp_valid", 128'(resp_valid), 128'(0));
        chk("rst_resp_rdata", resp_rdata, 128'd0);
        chk("rst_resp_err", 128'(resp_err), 128'(0));
        chk("rst_rvalid", 128'(r_request_valid), 128'(0));
        chk("rst_wvalid", 128'(w_request_valid), 128'(0));
        chk("rst_addrs", 128'({raddr, waddr}), 128'(0));
        chk("rst_wdata", wdata, 128'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_cmd_ready", 128'(cmd_ready), 128'(1));

        run_cmd(2'd0, 32'h0000_012C, 32'h0, 128'd0, 0, 2, 2'b00, 0, 2,
                128'hDEADBEEF_00112233_44556677_8899AABB, 2'b00, 0);
        run_cmd(2'd2, 32'h80, 32'h40, {4{32'h1111_1111}}, 0, 2, 2'b00, 0, 2, rnd_line(), 2'b00, 0);
        run_cmd(2'd1, 32'h0, 32'h1234_5678, rnd_line(), 5, 2, 2'b00, 0, 2, 128'd0, 2'b00, 0);
        run_cmd(2'd0, 32'hABCD_0000, 32'h0, 128'd0, 0, 2, 2'b00, 0, 2, rnd_line(), 2'b10, 0);
        run_cmd(2'd2, 32'h100, 32'h200, rnd_line(), 0, 2, 2'b01, 0, 2, rnd_line(), 2'b00, 0);
        run_cmd(2'd0, 32'h3F0, 32'h0, 128'd0, 0, 2, 2'b00, 0, TC + 5, rnd_line(), 2'b00, 0);
        stray_reply();
        run_cmd(2'd0, 32'h3F0, 32'h0, 128'd0, 0, 2, 2'b00, 0, 2, rnd_line(), 2'b00, 0);
        run_cmd(2'd1, 32'h0, 32'h500, rnd_line(), 0, TC + 3, 2'b00, 0, 2, 128'd0, 2'b00, 0);
        run_cmd(2'd0, 32'h777, 32'h0, 128'd0, 0, 2, 2'b00, 0, TC, rnd_line(), 2'b00, 0);
        run_cmd(2'd3, 32'h900, 32'hA00, rnd_line(), 0, 2, 2'b00, 0, 2, rnd_line(), 2'b00, 0);
        run_cmd(2'd0, 32'hC0, 32'h0, 128'd0, 0, 2, 2'b00, 0, 2, rnd_line(), 2'b00, 4);

        // Reset while waiting for a read reply.
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_addr = 32'h0000_0310;
        tick();
        cmd_valid = 1'b0;
        chk("rst_mid_rvalid", 128'(r_request_valid), 128'(1));
        r_request_ready = 1'b1;
        tick();
        r_request_ready = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("rst_mid_cmd_ready_low", 128'(cmd_ready), 128'(0));
        tick();
        rst = 1'b0;
        #1;
        chk("rst_mid_cmd_ready", 128'(cmd_ready), 128'(1));
        chk("rst_mid_rvalid_low", 128'(r_request_valid), 128'(0));
        chk("rst_mid_wvalid_low", 128'(w_request_valid), 128'(0));
        chk("rst_mid_resp_valid", 128'(resp_valid), 128'(0));
        chk("rst_mid_raddr", 128'(raddr), 128'(0));
        chk("rst_mid_rdata", resp_rdata, 128'd0);
        stray_reply();
        run_cmd(2'd0, 32'h440, 32'h0, 128'd0, 0, 2, 2'b00, 0, 2, rnd_line(), 2'b00, 0);

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(3, 0));
            run_cmd(op, $urandom, $urandom, rnd_line(),
                    int'($urandom_range(3, 0)),
                    ($urandom_range(7, 0) == 0) ? TC + 2 : int'($urandom_range(TC, 1)),
                    ($urandom_range(3, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'b00,
                    int'($urandom_range(3, 0)),
                    ($urandom_range(7, 0) == 0) ? TC + 2 : int'($urandom_range(TC, 1)),
                    rnd_line(),
                    ($urandom_range(3, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'b00,
                    int'($urandom_range(3, 0)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcache_line_master.md
Name: dcache_line_master

Overview:
- Initiator (master) end of the Mem_ift line protocol. It sits between the L1 data-cache controller and the data DRAM (the slave side).
- Accepts one line command at a time: refill, writeback, or writeback-then-refill.
- Drives the Mem_ift read/write request channels with 128-bit lines and collects the replies.
- Returns one response to the cache per command, with error reporting on non-zero resp codes or a reply timeout.

Parameters:
- ADDR_WIDTH, 32, byte-address width of cmd_addr, cmd_victim_addr and raddr/waddr.
- LINE_WIDTH, 128, line width in bits; the low $clog2(LINE_WIDTH/8) address bits are forced to zero on the bus.
- TIMEOUT_CYCLES, 64, maximum cycles to wait for a reply after a request handshake before flagging a timeout.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command; high only in IDLE.
- cmd_op  input  2  OP_REFILL=0, OP_WB=1, OP_WB_REFILL=2; 3 is reserved.
- cmd_addr  input  ADDR_WIDTH  refill address.
- cmd_victim_addr  input  ADDR_WIDTH  writeback address.
- cmd_wdata  input  LINE_WIDTH  victim line data.
- resp_valid  output  1  response present.
- resp_ready  input  1  cache accepts the response.
- resp_rdata  output  LINE_WIDTH  refilled line; zero for OP_WB.
- resp_err  output  2  RESP_OK=0, RESP_BUS=1 (non-zero rresp/bresp), RESP_TIMEOUT=2, RESP_BADOP=3.
- mem_ift  Mem_ift.Master  -  request/reply channels to the data DRAM.

Behaviour:
- Every output is a register or a decode of the registered state.
- Reset values:
  - cmd_ready=0 during the rst cycle, 1 afterwards.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - r_request_valid=0, w_request_valid=0, raddr=0, waddr=0, wdata=0.
- States: IDLE, W_REQ, W_WAIT, R_REQ, R_WAIT, RESP.
- IDLE:
  - cmd_ready=1. When cmd_valid is high, register the addresses (low 4 bits zeroed), cmd_wdata and the op.
  - Next state: REFILL -> R_REQ; WB and WB_REFILL -> W_REQ; reserved op -> RESP with RESP_BADOP and no bus traffic.
- W_REQ:
  - w_request_valid=1, with waddr/wdata held stable until handshake (w_request_valid && w_request_ready).
  - The handshake cycle goes to W_WAIT, and w_request_valid drops the cycle after the handshake. The valid must never stay high past the handshake, because the slave re-accepts held requests.
- W_WAIT:
  - Replies are never back-pressured; a reply is consumed in the cycle its valid is high.
  - On w_reply_valid: if bresp!=0, go to RESP with RESP_BUS and skip the refill. Otherwise WB goes to RESP with RESP_OK, and WB_REFILL goes to R_REQ.
- R_REQ / R_WAIT: same as the write path, using r_request_valid/raddr and r_reply_valid. Capture rdata into resp_rdata on reply; rresp!=0 gives RESP_BUS.
- Timeout:
  - A wait counter clears on entering W_WAIT/R_WAIT and increments each cycle in those states.
  - If it reaches TIMEOUT_CYCLES-1 with no reply, go to RESP with RESP_TIMEOUT and resp_rdata=0.
  - A reply arriving in the same cycle as the terminal count wins: it is treated as a normal reply.
- RESP: resp_valid=1, with data and err held stable until resp_ready; then go to IDLE. No new command is accepted in the RESP cycle.
- Latency against a slave that accepts immediately and replies 2 cycles after handshake:
  - REFILL: cmd handshake at T, request handshake at T+1, reply at T+3, resp_valid at T+4.
  - WB_REFILL: resp_valid at T+7.
- Stray replies (any reply valid outside W_WAIT/R_WAIT, e.g. after reset or after a timeout) are ignored. They change no state and no output.
- Read and write requests are never issued concurrently; at most one request is outstanding.
- Reset mid-operation: next cycle IDLE, all valids low, captured data cleared, counter cleared.

Decomposition:
- Package dcache_line_master_pkg holds:
  - op_t enum (OP_REFILL, OP_WB, OP_WB_REFILL);
  - state_t enum;
  - resp_err_t enum;
  - LINE_BYTES and LINE_OFFSET localparams.
- One sub-module, mem_reply_timer: a TIMEOUT_CYCLES counter with clear, enable and expired outputs, and synchronous reset.

Test Plan:
- REFILL, addr 0x0000_012C, slave returns 0xDEADBEEF_00112233_44556677_8899AABB, rresp=0 -> raddr=0x0000_0120, single-cycle request valid, resp_valid at T+4, resp_rdata equals the line, resp_err=0.
- WB_REFILL, victim 0x40 with data 0x1111..., refill 0x80 -> write handshake precedes the read request; waddr=0x40, raddr=0x80; one response with RESP_OK.
- Slave holds w_request_ready=0 for 5 cycles on a WB -> waddr/wdata stable, exactly one handshake, valid low the cycle after; RESP_OK.
- REFILL with rresp=2'b10 -> RESP_BUS; WB_REFILL with bresp!=0 -> no read request issued, RESP_BUS.
- Slave never replies, TIMEOUT_CYCLES=8 -> RESP_TIMEOUT on the 8th wait cycle. A late reply afterwards is ignored, and the next REFILL completes OK.
- Also cover:
  - cmd_op=3 -> RESP_BADOP with zero bus activity;
  - resp_ready held low 4 cycles -> resp held;
  - rst asserted in R_WAIT -> IDLE next cycle with all valids 0, and the pending reply ignored.
